imm_extend_pipe: RTL and testbench

Two-stage, handshaked immediate-extension unit for the processor's decode/execute boundary. It accepts a 24-bit instruction immediate field, a format select and a tag. It produces a DATA_WIDTH-bit operand from one of three ISA formats: data-processing imm8 with optional rotation, memory imm12, and signed branch offset ×4. It replaces the combinational extender on pipelined datapaths, with valid/ready flow control, back-pressure and flush.

---
 rtl/imm_extend_pipe.sv | 123 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender (DP imm8, MEM imm12, BRANCH offset x4).
// Define IMM_EXTEND_ROTATE_EN to enable the DP imm8 rotate-right by 2*imm[11:8].
module imm_extend_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_imm_src,
  input  logic [23:0]           in_imm,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  localparam int unsigned IMM_WIDTH = 24;
  localparam int unsigned SEXT_BITS = DATA_WIDTH - IMM_WIDTH - 2;

  typedef enum logic [1:0] {
    SRC_DP     = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_RSVD   = 2'd3
  } imm_src_t;

  logic                  s1_valid;
  imm_src_t              s1_src;
  logic [IMM_WIDTH-1:0]  s1_imm;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_free;
  logic                  accept;
  logic                  advance;
  logic [DATA_WIDTH-1:0] dp_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  err_c;

  // Handshake chain: S2 frees on drain, S1 frees when S2 can take its beat.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready && !flush;
  assign advance  = s1_valid && s2_free && !flush;

`ifdef IMM_EXTEND_ROTATE_EN
  logic [63:0] dp_dbl;
  logic [4:0]  dp_amt;
  logic [31:0] dp_rot;

  // Rotate right expressed as a shift of the value concatenated with itself.
  always_comb begin
    dp_amt = {s1_imm[11:8], 1'b0};
    dp_dbl = {2{24'd0, s1_imm[7:0]}};
    dp_rot = 32'(dp_dbl >> dp_amt);
  end
  assign dp_c = DATA_WIDTH'(dp_rot);
`else
  assign dp_c = DATA_WIDTH'(s1_imm[7:0]);
`endif

  // Format selection for the beat leaving S1.
  always_comb begin
    result_c = '0;
    err_c    = 1'b0;
    case (s1_src)
      SRC_DP:     result_c = dp_c;
      SRC_MEM:    result_c = DATA_WIDTH'(s1_imm[11:0]);
      SRC_BRANCH: result_c = {{SEXT_BITS{s1_imm[IMM_WIDTH-1]}}, s1_imm, 2'b00};
      SRC_RSVD:   err_c    = 1'b1;
      default:    err_c    = 1'b1;
    endcase
  end

  // S1 capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src   <= SRC_DP;
      s1_imm   <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_src <= imm_src_t'(in_imm_src);
        s1_imm <= in_imm;
        s1_tag <= in_tag;
      end
    end
  end

  // S2 output register; payload only moves on advance so stalls hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (advance) begin
        out_result <= result_c;
        out_tag    <= s1_tag;
        out_err    <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe; expectations follow
// IMM_EXTEND_ROTATE_EN when the bench is built with the same macro.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [23:0] in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_src(in_imm_src), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; everything is driven and sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] src, input logic [23:0] imm, input logic [4:0] tag);
    in_valid   = 1'b1;
    in_imm_src = src;
    in_imm     = imm;
    in_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm_src = 2'd0;
    in_imm = 24'd0; in_tag = 5'd0; out_ready = 1'b0;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (out_result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", out_result); end
    tests++; if (out_tag !== 5'd0) begin fails++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", out_err); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mem();
    out_ready = 1'b1;
    offer(2'd1, 24'h000ABC, 5'd3);
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mem_latency1 got=%b exp=0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mem_valid got=%b exp=1", out_valid); end
    tests++; if (out_result !== 32'h00000ABC) begin fails++; $display("FAIL mem_result got=%h exp=00000abc", out_result); end
    tests++; if (out_tag !== 5'd3) begin fails++; $display("FAIL mem_tag got=%0d exp=3", out_tag); end
    tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL mem_err got=%b exp=0", out_err); end
    offer(2'd1, 24'hFFF123, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_result !== 32'h00000123) begin fails++; $display("FAIL mem_ignore_hi got=%h exp=00000123", out_result); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mem_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    offer(2'd2, 24'hFFFFFE, 5'd1);
    tick();
    offer(2'd2, 24'h000010, 5'd2);
    tick();
    in_valid = 1'b0;
    tests++; if (out_result !== 32'hFFFFFFF8 || out_tag !== 5'd1 || out_valid !== 1'b1)
      begin fails++; $display("FAIL br_neg got=%h/%0d/%b exp=fffffff8/1/1", out_result, out_tag, out_valid); end
    tick();
    tests++; if (out_result !== 32'h00000040 || out_tag !== 5'd2 || out_valid !== 1'b1)
      begin fails++; $display("FAIL br_pos got=%h/%0d/%b exp=00000040/2/1", out_result, out_tag, out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL br_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_dp();
    logic [31:0] exp_a;
    logic [31:0] exp_c;
`ifdef IMM_EXTEND_ROTATE_EN
    exp_a = 32'hFF000000;
    exp_c = 32'h00000004;
`else
    exp_a = 32'h000000FF;
    exp_c = 32'h00000001;
`endif
    out_ready = 1'b1;
    offer(2'd0, 24'h0004FF, 5'd5);
    tick();
    offer(2'd0, 24'h0000A5, 5'd6);
    tick();
    offer(2'd0, 24'h000F01, 5'd7);
    tests++; if (out_result !== exp_a) begin fails++; $display("FAIL dp_rot8 got=%h exp=%h", out_result, exp_a); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_result !== 32'h000000A5 || out_tag !== 5'd6)
      begin fails++; $display("FAIL dp_plain got=%h/%0d exp=000000a5/6", out_result, out_tag); end
    tick();
    tests++; if (out_result !== exp_c || out_err !== 1'b0)
      begin fails++; $display("FAIL dp_rot30 got=%h/%b exp=%h/0", out_result, out_err, exp_c); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(2'd1, 24'h000001, 5'd1);
    tick();
    offer(2'd1, 24'h000002, 5'd2);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    tick();
    offer(2'd1, 24'h000003, 5'd3);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    tests++; if (out_tag !== 5'd1 || out_result !== 32'd1) begin fails++; $display("FAIL bp_head got=%0d/%h exp=1/00000001", out_tag, out_result); end
    tick();
    tests++; if (out_tag !== 5'd1 || out_result !== 32'd1 || out_valid !== 1'b1)
      begin fails++; $display("FAIL bp_hold got=%0d/%h/%b exp=1/00000001/1", out_tag, out_result, out_valid); end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    offer(2'd1, 24'h000004, 5'd4);
    tests++; if (out_tag !== 5'd2) begin fails++; $display("FAIL bp_order2 got=%0d exp=2", out_tag); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_tag !== 5'd3 || out_result !== 32'd3) begin fails++; $display("FAIL bp_order3 got=%0d/%h exp=3/00000003", out_tag, out_result); end
    tick();
    tests++; if (out_tag !== 5'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_order4 got=%0d/%b exp=4/1", out_tag, out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(2'd1, 24'h000005, 5'd5);
    tick();
    offer(2'd1, 24'h000006, 5'd6);
    tick();
    offer(2'd1, 24'h000777, 5'd7);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fl_ready_during got=%b exp=1", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL fl_clear got=%b/%b exp=0/1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_no_ghost cyc=%0d got=%b tag=%0d exp=0", i, out_valid, out_tag); end
    end
    offer(2'd3, 24'hABCDEF, 5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_err !== 1'b1 || out_tag !== 5'd9)
      begin fails++; $display("FAIL rsvd got=%b/%h/%b/%0d exp=1/00000000/1/9", out_valid, out_result, out_err, out_tag); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(2'd2, 24'h000100, 5'd17);
    tick();
    offer(2'd1, 24'h000FFF, 5'd31);
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h00000400)
      begin fails++; $display("FAIL ar_prefill got=%b/%b/%h exp=1/0/00000400", out_valid, in_ready, out_result); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0 || out_err !== 1'b0)
      begin fails++; $display("FAIL ar_outputs got=%b/%h/%0d/%b exp=0/0/0/0", out_valid, out_result, out_tag, out_err); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    offer(2'd1, 24'h000321, 5'd8);
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_no_stale got=%b exp=0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_result !== 32'h00000321 || out_tag !== 5'd8)
      begin fails++; $display("FAIL ar_first_beat got=%b/%h/%0d exp=1/00000321/8", out_valid, out_result, out_tag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mem();
    test_back_to_back();
    test_dp();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
